// File: rtl/operand_fetch.sv
// operand_fetch: register file read with writeback bypass, busy-bit scoreboard and a one-entry operand output register.
`ifndef WIDTH
`define WIDTH 32
`endif
module operand_fetch #(
  parameter int WIDTH = `WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_opcode,
  input  logic [3:0]       in_rd,
  input  logic [3:0]       in_rs1,
  input  logic [3:0]       in_rs2,
  input  logic [WIDTH-1:0] in_imm,
  input  logic             in_use_imm,
  input  logic             wb_en,
  input  logic [3:0]       wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_opcode,
  output logic [3:0]       out_rd,
  output logic [WIDTH-1:0] out_data_a,
  output logic [WIDTH-1:0] out_data_b
);
  logic [WIDTH-1:0] r_rf [16];
  logic [15:0]      r_busy;
  logic             w_byp1, w_byp2, w_hazard, w_accept;
  logic [WIDTH-1:0] w_a, w_b;
  logic [15:0]      w_set, w_clr;
  assign w_byp1   = wb_en && wb_addr == in_rs1 && in_rs1 != 4'd0;
  assign w_byp2   = wb_en && wb_addr == in_rs2 && in_rs2 != 4'd0;
  assign w_a      = in_rs1 == 4'd0 ? '0 : w_byp1 ? wb_data : r_rf[in_rs1];
  assign w_b      = in_use_imm ? in_imm : in_rs2 == 4'd0 ? '0 : w_byp2 ? wb_data : r_rf[in_rs2];
  // r0 never has its busy bit set, so no explicit r0 term is needed here
  assign w_hazard = (r_busy[in_rs1] && !w_byp1) || (!in_use_imm && r_busy[in_rs2] && !w_byp2);
  assign in_ready = !rst && (!out_valid || out_ready) && !w_hazard;
  assign w_accept = in_valid && in_ready;
  assign w_set    = (w_accept && in_rd != 4'd0) ? 16'd1 << in_rd : 16'd0;
  assign w_clr    = wb_en ? 16'd1 << wb_addr : 16'd0;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) r_rf[i] <= '0;
      r_busy <= '0;
    end else begin
      if (wb_en && wb_addr != 4'd0) r_rf[wb_addr] <= wb_data;
      r_busy <= w_set | (r_busy & ~w_clr);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_opcode <= '0;
      out_rd     <= '0;
      out_data_a <= '0;
      out_data_b <= '0;
    end else if (w_accept) begin
      out_valid  <= 1'b1;
      out_opcode <= in_opcode;
      out_rd     <= in_rd;
      out_data_a <= w_a;
      out_data_b <= w_b;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed vectors with hand-computed expectations for operand_fetch.
module tb_operand_fetch;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, in_use_imm, wb_en, out_valid, out_ready;
  logic [4:0]  in_opcode, out_opcode;
  logic [3:0]  in_rd, in_rs1, in_rs2, wb_addr, out_rd;
  logic [31:0] in_imm, wb_data, out_data_a, out_data_b;
  int checks = 0;
  int errors = 0;
  operand_fetch dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .in_use_imm(in_use_imm), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_rd(out_rd), .out_data_a(out_data_a), .out_data_b(out_data_b)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic issue(input logic v, input logic [4:0] opc, input logic [3:0] rd, input logic [3:0] rs1,
                       input logic [3:0] rs2, input logic ui, input logic [31:0] imm);
    in_valid = v; in_opcode = opc; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_use_imm = ui; in_imm = imm;
  endtask
  task automatic wb(input logic en, input logic [3:0] a, input logic [31:0] d);
    wb_en = en; wb_addr = a; wb_data = d;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1; out_ready = 1'b1;
    issue(1, 5'd9, 4'd2, 4'd0, 4'd0, 0, 32'd0);
    wb(0, 4'd0, 32'd0);
    #1;
    chk("rst_ready", 32'(in_ready), 32'd0);
    tick; tick;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_opc", 32'(out_opcode), 32'd0);
    chk("rst_rd", 32'(out_rd), 32'd0);
    chk("rst_a", out_data_a, 32'd0);
    chk("rst_b", out_data_b, 32'd0);
    rst = 1'b0;
    issue(0, 5'd0, 4'd0, 4'd0, 4'd0, 0, 32'd0);
    wb(1, 4'd3, 32'h10);
    #1;
    chk("first_ready", 32'(in_ready), 32'd1);
    tick;
    issue(1, 5'd1, 4'd4, 4'd3, 4'd0, 0, 32'd0);
    wb(0, 4'd0, 32'd0);
    tick;
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("add_opc", 32'(out_opcode), 32'd1);
    chk("add_rd", 32'(out_rd), 32'd4);
    chk("add_a", out_data_a, 32'h10);
    chk("add_b", out_data_b, 32'd0);
    issue(0, 5'd0, 4'd0, 4'd4, 4'd0, 0, 32'd0);
    #1;
    chk("busy4_stall", 32'(in_ready), 32'd0);
    issue(1, 5'd1, 4'd0, 4'd4, 4'd3, 0, 32'd0);
    wb(1, 4'd4, 32'h44);
    #1;
    chk("busy4_clr_ready", 32'(in_ready), 32'd1);
    tick;
    chk("byp4_a", out_data_a, 32'h44);
    chk("rf3_b", out_data_b, 32'h10);
    issue(1, 5'd2, 4'd7, 4'd5, 4'd0, 0, 32'd0);
    wb(1, 4'd5, 32'hAB);
    tick;
    chk("byp5_a", out_data_a, 32'hAB);
    chk("byp5_rd", 32'(out_rd), 32'd7);
    issue(1, 5'd1, 4'd6, 4'd0, 4'd0, 0, 32'd0);
    wb(0, 4'd0, 32'd0);
    tick;
    issue(1, 5'd1, 4'd0, 4'd6, 4'd0, 0, 32'd0);
    #1;
    chk("raw6_stall", 32'(in_ready), 32'd0);
    tick;
    chk("raw6_bubble", 32'(out_valid), 32'd0);
    chk("raw6_stall2", 32'(in_ready), 32'd0);
    wb(1, 4'd6, 32'h7);
    #1;
    chk("raw6_wb_ready", 32'(in_ready), 32'd1);
    tick;
    chk("raw6_a", out_data_a, 32'h7);
    chk("raw6_valid", 32'(out_valid), 32'd1);
    wb(0, 4'd0, 32'd0);
    out_ready = 1'b0;
    issue(1, 5'd3, 4'd0, 4'd3, 4'd0, 0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready", 32'(in_ready), 32'd0);
      tick;
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_a", out_data_a, 32'h7);
      chk("bp_opc", 32'(out_opcode), 32'd1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    tick;
    chk("b2b1_opc", 32'(out_opcode), 32'd3);
    chk("b2b1_a", out_data_a, 32'h10);
    issue(1, 5'd4, 4'd0, 4'd5, 4'd0, 0, 32'd0);
    #1;
    chk("b2b_ready", 32'(in_ready), 32'd1);
    tick;
    chk("b2b2_valid", 32'(out_valid), 32'd1);
    chk("b2b2_opc", 32'(out_opcode), 32'd4);
    chk("b2b2_a", out_data_a, 32'hAB);
    issue(1, 5'd5, 4'd0, 4'd0, 4'd7, 0, 32'hFFFF_FFFF);
    #1;
    chk("rs2_busy_stall", 32'(in_ready), 32'd0);
    in_use_imm = 1'b1;
    #1;
    chk("imm_ready", 32'(in_ready), 32'd1);
    tick;
    chk("imm_b", out_data_b, 32'hFFFF_FFFF);
    issue(1, 5'd6, 4'd0, 4'd0, 4'd0, 0, 32'd0);
    wb(1, 4'd0, 32'h55);
    tick;
    chk("r0_byp_a", out_data_a, 32'd0);
    wb(1, 4'd8, 32'h88);
    tick;
    chk("r0_a", out_data_a, 32'd0);
    chk("r0_b", out_data_b, 32'd0);
    issue(1, 5'd7, 4'd10, 4'd8, 4'd0, 0, 32'd0);
    wb(1, 4'd10, 32'h1);
    #1;
    chk("nonbusy_wb_ready", 32'(in_ready), 32'd1);
    tick;
    chk("nonbusy_wb_a", out_data_a, 32'h88);
    issue(0, 5'd0, 4'd0, 4'd10, 4'd0, 0, 32'd0);
    wb(0, 4'd0, 32'd0);
    #1;
    chk("set_wins", 32'(in_ready), 32'd0);
    issue(1, 5'd8, 4'd9, 4'd0, 4'd0, 0, 32'd0);
    tick;
    out_ready = 1'b0;
    issue(0, 5'd0, 4'd0, 4'd0, 4'd0, 0, 32'd0);
    tick;
    chk("held_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_ready", 32'(in_ready), 32'd0);
    tick;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_opc", 32'(out_opcode), 32'd0);
    chk("midrst_rd", 32'(out_rd), 32'd0);
    rst = 1'b0; out_ready = 1'b1;
    issue(1, 5'd2, 4'd0, 4'd9, 4'd10, 0, 32'd0);
    #1;
    chk("midrst_busy_clear", 32'(in_ready), 32'd1);
    tick;
    chk("midrst_valid2", 32'(out_valid), 32'd1);
    issue(1, 5'd2, 4'd0, 4'd3, 4'd8, 0, 32'd0);
    tick;
    chk("rf_zero_a", out_data_a, 32'd0);
    chk("rf_zero_b", out_data_b, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
